// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types; adds the issue-scheduler state encoding.
package rv32i_types;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
  } sal_t;

  typedef enum logic {SCHED_EMPTY, SCHED_FULL} acu_sched_state_t;

endpackage

// File: rtl/acu_issue_sched_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping at size.
module rr_pick #(
  parameter int size  = 15,
  parameter int PTR_W = (size > 1) ? $clog2(size) : 1
) (
  input  logic [size-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx,
  output logic [size-1:0]  onehot
);

  logic [PTR_W:0] w_pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    w_pos  = '0;
    for (int k = size - 1; k >= 0; k--) begin
      w_pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_pos >= (PTR_W+1)'(size)) w_pos = w_pos - (PTR_W+1)'(size);
      if (req[w_pos[PTR_W-1:0]]) begin
        any    = 1'b1;
        idx    = w_pos[PTR_W-1:0];
        onehot = '0;
        onehot[w_pos[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acu_issue_sched.sv
// Round-robin pick of one ready ACU entry per cycle into a one-deep CDB slot.
module acu_issue_sched
  import rv32i_types::*;
#(
  parameter int size = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [size-1:0]       ready,
  input  sal_t [size-1:0]       acu_result,
  input  logic                  cdb_ack,
  output logic                  cdb_valid,
  output sal_t                  cdb_data,
  output logic [size-1:0]       entry_clear
);

  localparam int PTR_W = (size > 1) ? $clog2(size) : 1;

  acu_sched_state_t r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  sal_t             r_data;

  logic             w_any, w_can_take, w_grant;
  logic [PTR_W-1:0] w_idx;
  logic [size-1:0]  w_onehot;

  rr_pick #(.size(size), .PTR_W(PTR_W)) u_pick (
    .req    (ready),
    .ptr    (r_ptr),
    .any    (w_any),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  assign w_can_take  = (r_state == SCHED_EMPTY) | ((r_state == SCHED_FULL) & cdb_ack);
  assign w_grant     = w_can_take & w_any & ~flush;
  assign entry_clear = (w_grant & rst) ? w_onehot : '0;
  assign cdb_valid   = (r_state == SCHED_FULL);
  assign cdb_data    = r_data;

  // Flush beats grant and ack; a grant refills the slot even while draining.
  always_comb begin
    w_state_nxt = r_state;
    if (flush)                                 w_state_nxt = SCHED_EMPTY;
    else if (w_grant)                          w_state_nxt = SCHED_FULL;
    else if ((r_state == SCHED_FULL) & cdb_ack) w_state_nxt = SCHED_EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SCHED_EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_data <= acu_result[w_idx];
        r_ptr  <= (w_idx == PTR_W'(size - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acu_issue_sched.sv
// Directed bench for acu_issue_sched: reset, order, backpressure, wrap, flush, fairness.
module tb_acu_issue_sched;
  import rv32i_types::*;

  localparam int SZ = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [SZ-1:0]   ready;
  sal_t [SZ-1:0]   acu_result;
  logic            cdb_ack;
  logic            cdb_valid;
  sal_t            cdb_data;
  logic [SZ-1:0]   entry_clear;

  int checks = 0;
  int errors = 0;

  acu_issue_sched #(.size(SZ)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .ready       (ready),
    .acu_result  (acu_result),
    .cdb_ack     (cdb_ack),
    .cdb_valid   (cdb_valid),
    .cdb_data    (cdb_data),
    .entry_clear (entry_clear)
  );

  always #5 clk = ~clk;

  function automatic sal_t res(input int i);
    sal_t r;
    r.data = 32'hA5A5_0000 | 32'(i);
    r.tag  = 6'(i + 1);
    return r;
  endfunction

  function automatic logic [SZ-1:0] oh(input int i);
    logic [SZ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Slot contents after an edge.
  task automatic chk_slot(input string tag, input logic v, input int i);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    if (v) chk({tag, ".data"}, 64'(cdb_data), 64'(res(i)));
  endtask

  task automatic chk_clr(input string tag, input logic [SZ-1:0] exp);
    #1;
    chk({tag, ".clear"}, 64'(entry_clear), 64'(exp));
  endtask

  initial begin
    for (int i = 0; i < SZ; i++) acu_result[i] = res(i);
    rst = 1'b0; flush = 1'b0; ready = '0; cdb_ack = 1'b0;

    // 1: reset
    #2;
    ready = 15'h0001;
    chk_clr("rst_clear", '0);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_data", 64'(cdb_data), 64'd0);
    @(negedge clk); rst = 1'b1;
    cyc();
    chk_slot("rst_fill", 1'b1, 0);
    ready = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(cdb_valid), 64'd0);
    chk("rst_mid_data", 64'(cdb_data), 64'd0);
    @(negedge clk); rst = 1'b1;
    cyc(); cyc();
    chk("rst_idle", 64'(cdb_valid), 64'd0);

    // 2: in-order pick from ptr=0
    cdb_ack = 1'b1; ready = 15'h0005;
    chk_clr("t2_g0", 15'h0001);
    cyc(); chk_slot("t2_s0", 1'b1, 0);
    ready = 15'h0004;
    chk_clr("t2_g2", 15'h0004);
    cyc(); chk_slot("t2_s2", 1'b1, 2);
    ready = '0;
    chk_clr("t2_none", '0);
    cyc(); chk_slot("t2_drain", 1'b0, 0);

    // 3: backpressure, ptr=3
    cdb_ack = 1'b0; ready = 15'h0008;
    chk_clr("t3_g3", 15'h0008);
    cyc(); chk_slot("t3_s3", 1'b1, 3);
    ready = 15'h0100;
    for (int k = 0; k < 3; k++) begin
      chk_clr("t3_hold_clr", '0);
      cyc(); chk_slot("t3_hold", 1'b1, 3);
    end
    cdb_ack = 1'b1;
    chk_clr("t3_g8", 15'h0100);
    cyc(); chk_slot("t3_s8", 1'b1, 8);
    ready = '0;
    cyc(); chk_slot("t3_drain", 1'b0, 0);

    // 4: wrap; grant 13 to land ptr on 14
    ready = oh(13);
    chk_clr("t4_g13", oh(13));
    cyc(); chk_slot("t4_s13", 1'b1, 13);
    ready = '0;
    cyc();
    ready = 15'h4002;
    chk_clr("t4_g14", 15'h4000);
    cyc(); chk_slot("t4_s14", 1'b1, 14);
    ready = 15'h0002;
    chk_clr("t4_g1", 15'h0002);
    cyc(); chk_slot("t4_s1", 1'b1, 1);
    ready = '0;
    cyc(); chk_slot("t4_drain", 1'b0, 0);

    // 5: flush while full with ack; ptr=2 -> grant 2 -> ptr=3
    ready = 15'h0004;
    chk_clr("t5_g2", 15'h0004);
    cyc(); chk_slot("t5_s2", 1'b1, 2);
    ready = 15'h0010; flush = 1'b1;
    chk_clr("t5_flush_clr", '0);
    cyc(); chk_slot("t5_flushed", 1'b0, 0);
    flush = 1'b0; ready = 15'h0011;
    chk_clr("t5_g4", 15'h0010);
    cyc(); chk_slot("t5_s4", 1'b1, 4);
    ready = 15'h0001;
    chk_clr("t5_g0", 15'h0001);
    cyc(); chk_slot("t5_s0", 1'b1, 0);
    ready = '0;
    cyc(); chk_slot("t5_drain", 1'b0, 0);

    // 6: fairness; grant 14 first so ptr returns to 0
    ready = oh(14);
    chk_clr("t6_g14", oh(14));
    cyc(); chk_slot("t6_s14", 1'b1, 14);
    ready = '1;
    for (int k = 0; k <= SZ; k++) begin
      chk_clr("t6_rr_clr", oh(k % SZ));
      cyc(); chk_slot("t6_rr", 1'b1, k % SZ);
    end
    ready = '0;
    cyc(); chk_slot("t6_drain", 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
